// File: rtl/str_lock_output.sv
// str_lock_output: output stage of the symbol timing recovery chain.
// Scales each strobed I/Q pair by 2^GAIN_SHIFT with saturation, runs a lock
// detector on the TED error magnitude, and queues symbols into a FIFO whose
// head is held in registers.
//
// Handshake: a symbol transfers on every rising clk edge where
// out_valid && out_ready. out_valid never depends combinationally on
// out_ready, and I_out/Q_out stay stable while out_valid && !out_ready.
module str_lock_output #(
   parameter int IN_W          = 16,
   parameter int OUT_W         = 17,
   parameter int GAIN_SHIFT    = 1,
   parameter int ERR_W         = 32,
   parameter int LOCK_THR      = 4096,
   parameter int LOCK_CNT      = 16,
   parameter int UNLOCK_CNT    = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter bit GATE_UNLOCKED = 1'b1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            strobe,
   input  logic signed [IN_W-1:0]          I_interp,
   input  logic signed [IN_W-1:0]          Q_interp,
   input  logic                            ted_out_en,
   input  logic signed [ERR_W-1:0]         er,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic signed [OUT_W-1:0]         I_out,
   output logic signed [OUT_W-1:0]         Q_out,
   output logic                            locked,
   output logic [1:0]                      lock_state,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   output logic [15:0]                     drop_cnt
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int GW  = $clog2(LOCK_CNT + 1);
   localparam int BW  = $clog2(UNLOCK_CNT + 1);
   localparam int MW  = ERR_W + 1;
   localparam int SHW = IN_W + GAIN_SHIFT;
   localparam int SW  = ((SHW > OUT_W) ? SHW : OUT_W) + 1;
   localparam int DW  = 2 * OUT_W;

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_ACQ    = 2'd0,
      ST_LOCKED = 2'd1,
      ST_HOLD   = 2'd2
   } lock_state_e;

   lock_state_e     state_q, state_d;
   logic [GW-1:0]   good_cnt_q, good_cnt_d;
   logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
   logic            locked_q, locked_d;

   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [DW-1:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            valid_q, valid_d;
   logic [DW-1:0]   head_q, head_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     drop_q, drop_d;

   logic [MW-1:0]   er_ext, er_mag;
   logic            err_good;
   logic signed [OUT_W-1:0] i_sc, q_sc;
   logic [DW-1:0]   push_word;
   logic            push_req, pop, full, push, drop;

   // Sign-extend, shift by the gain, clamp to the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [IN_W-1:0] x);
      logic signed [SW-1:0] wide;
      wide = {{(SW-IN_W){x[IN_W-1]}}, x};
      wide = wide <<< GAIN_SHIFT;
      if (wide > SAT_MAX) begin
         scale_sat = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (wide < SAT_MIN) begin
         scale_sat = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         scale_sat = wide[OUT_W-1:0];
      end
   endfunction

   // Error magnitude in one extra bit so the most-negative error cannot wrap.
   always_comb begin
      er_ext   = {er[ERR_W-1], er};
      er_mag   = er[ERR_W-1] ? (~er_ext + MW'(1)) : er_ext;
      err_good = (er_mag < MW'(LOCK_THR));
   end

   // Lock detector next state: only a valid TED error moves it.
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      case (state_q)
         ST_ACQ: begin
            if (ted_out_en) begin
               if (err_good) begin
                  if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
                     state_d    = ST_LOCKED;
                     good_cnt_d = '0;
                  end else begin
                     good_cnt_d = good_cnt_q + GW'(1);
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (ted_out_en && !err_good) begin
               state_d   = ST_HOLD;
               bad_cnt_d = BW'(1);
            end
         end
         ST_HOLD: begin
            if (ted_out_en) begin
               if (err_good) begin
                  state_d   = ST_LOCKED;
                  bad_cnt_d = '0;
               end else if (bad_cnt_q == BW'(UNLOCK_CNT - 1)) begin
                  state_d    = ST_ACQ;
                  bad_cnt_d  = '0;
                  good_cnt_d = '0;
               end else begin
                  bad_cnt_d = bad_cnt_q + BW'(1);
               end
            end
         end
         default: begin
            state_d    = ST_ACQ;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
         end
      endcase
      locked_d = (state_d != ST_ACQ);
   end

   // FIFO next state: gated push, pop, drop accounting and head refresh.
   always_comb begin
      i_sc      = scale_sat(I_interp);
      q_sc      = scale_sat(Q_interp);
      push_word = {i_sc, q_sc};
      push_req  = strobe && (!GATE_UNLOCKED || locked_q);
      pop       = valid_q && out_ready;
      full      = (level_q == LW'(FIFO_DEPTH));
      push      = push_req && (!full || pop);
      drop      = push_req && full && !pop;

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_word;
      end
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      valid_d = (level_d != '0);

      // The head reloads when the old one leaves or the FIFO was empty; if the
      // new head is the word being written this cycle, take it directly.
      head_d = head_q;
      if (valid_d && (pop || !valid_q)) begin
         head_d = (push && (rd_ptr_d == wr_ptr_q)) ? push_word : mem_q[rd_ptr_d];
      end

      ovf_d  = ovf_q | drop;
      drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
   end

   // State registers; reset discards lock state and queued symbols at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ACQ;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         locked_q   <= 1'b0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_q[k] <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         valid_q    <= 1'b0;
         head_q     <= '0;
         ovf_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         locked_q   <= locked_d;
         mem_q      <= mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         valid_q    <= valid_d;
         head_q     <= head_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
      end
   end

   assign out_valid  = valid_q;
   assign I_out      = head_q[DW-1:OUT_W];
   assign Q_out      = head_q[OUT_W-1:0];
   assign locked     = locked_q;
   assign lock_state = state_q;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;
   assign drop_cnt   = drop_q;

endmodule

// File: doc/str_lock_output.md
Name: str_lock_output

Overview:
- Parametrised output stage for the symbol timing recovery chain; generalises the existing strobe-gated, gain-of-2 I/Q output register.
- Sits after the interpolators and Gardner TED.
- Consumes the per-symbol strobe, the interpolated I/Q samples and the TED error.
- Adds configurable gain with saturation, a lock-detector FSM driven by TED error magnitude, lock-gated symbol emission, and a FIFO with valid/ready handshake toward downstream demapping.

Parameters:
IN_W, 16, width of I/Q interpolated samples (signed)
OUT_W, 17, width of I/Q output symbols (signed), OUT_W >= IN_W
GAIN_SHIFT, 1, output = input << GAIN_SHIFT, saturated to OUT_W
ERR_W, 32, width of TED error input (signed)
LOCK_THR, 4096, |er| strictly below this counts as a good symbol
LOCK_CNT, 16, consecutive good errors needed to declare lock
UNLOCK_CNT, 8, consecutive bad errors in HOLD needed to drop lock
FIFO_DEPTH, 8, output FIFO entries, power of 2, >= 2
GATE_UNLOCKED, 1, 1 = push symbols only while locked; 0 = push every strobe

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
strobe  in  1  symbol strobe from NCO; one sample pair per pulse
I_interp  in  IN_W  interpolated I sample, valid when strobe=1
Q_interp  in  IN_W  interpolated Q sample, valid when strobe=1
ted_out_en  in  1  TED error valid
er  in  ERR_W  TED timing error
out_valid  out  1  head symbol available
out_ready  in  1  downstream accepts symbol
I_out  out  OUT_W  head I symbol
Q_out  out  OUT_W  head Q symbol
locked  out  1  lock indication
lock_state  out  2  FSM state: 0=ACQ, 1=LOCKED, 2=HOLD
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a symbol was dropped
drop_cnt  out  16  saturating count of dropped symbols

Behaviour:
- Reset (async, active-high) clears everything: outputs 0, FSM=ACQ, FIFO empty, counters 0, overflow 0. Reset mid-operation discards FIFO contents and lock state immediately.
- Error magnitude is evaluated only when ted_out_en=1.
  - |er| is computed in ERR_W+1 bits, so the most-negative er is handled without wrap.
  - good = |er| < LOCK_THR; bad otherwise.
- FSM, updated only on ted_out_en:
  - ACQ: good increments good_cnt; bad clears it. When good_cnt reaches LOCK_CNT, go to LOCKED and clear good_cnt.
  - LOCKED: good stays; bad goes to HOLD with bad_cnt=1.
  - HOLD: good returns to LOCKED and clears bad_cnt. Bad increments bad_cnt; when bad_cnt reaches UNLOCK_CNT, go to ACQ and clear both counters.
  - Encoding 3 is unreachable and recovers to ACQ on the next clock.
- locked is registered: 1 in LOCKED and HOLD, 0 in ACQ. It updates the cycle after the deciding ted_out_en.
- Push condition: strobe && (GATE_UNLOCKED==0 || locked). The registered locked is used, so a strobe coincident with the lock-deciding ted_out_en is gated by the old state.
- Scaling: value = sample sign-extended, shifted left by GAIN_SHIFT, then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. I and Q saturate independently.
- FIFO:
  - Registered head; I_out/Q_out/out_valid come from registers.
  - A push into an empty FIFO gives out_valid=1 on the next cycle (latency 1 clk from strobe).
  - Pop occurs when out_valid && out_ready.
  - While out_valid && !out_ready, I_out/Q_out hold stable.
  - When out_valid=0, I_out/Q_out hold their last value.
- Boundaries:
  - Full, push with no pop: symbol dropped, overflow set (sticky until reset), drop_cnt += 1, saturating at 0xFFFF.
  - Full, push and pop in the same cycle: push accepted, level unchanged, no drop.
  - Empty, push with out_ready=1: no same-cycle bypass; the symbol appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level ranges 0..FIFO_DEPTH.
- Lock loss does not flush the FIFO; already-queued symbols still drain.

Test Plan:
1. Reset, GATE_UNLOCKED=1; 20 strobes with ted_out_en and er=100 each symbol -> no pushes until locked; lock_state=1 one cycle after the 16th good error; subsequent strobes push; fifo_level increments.
2. Locked; I_interp=20000, Q_interp=-20000, GAIN_SHIFT=1, OUT_W=17 -> I_out=40000, Q_out=-40000. Then I_interp=32767 with GAIN_SHIFT=2 -> I_out=65535 (saturated).
3. Locked; 7 errors er=-5000 -> lock_state=2, locked=1. One er=10 -> lock_state=1. Then 8 errors er=-2^31 -> lock_state=0, locked=0 one cycle after the 8th.
4. out_ready=0; 10 pushes into depth 8 -> fifo_level=8, overflow=1, drop_cnt=2. Head stays the first pushed symbol. Release out_ready -> 8 symbols drain in order, out_valid falls after the last.
5. FIFO full; push with out_ready=1 in the same cycle -> level stays 8, drop_cnt unchanged, the new symbol emerges last.
6. Assert reset asynchronously mid-drain while locked -> out_valid, locked, fifo_level, overflow, drop_cnt all 0 before the next clk edge; lock_state=0.
